// File: rtl/clock_div_seq.sv
// rtl/clock_div_seq.sv - lock-qualified reset sequencer with NCH programmable clock-enable dividers
// Optional feature macro: CLOCK_DIV_SEQ_LOSS_CNT_EN (saturating lock-loss event counter)
module clock_div_seq #(
  parameter int NCH         = 2,
  parameter int DW          = 8,
  parameter int DEF_DIV     = 4,
  parameter int LOCK_WAIT   = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              locked_in,
  input  logic [NCH*DW-1:0] div_cfg,
  input  logic              cfg_load,
  output logic [NCH-1:0]    ce_out,
  output logic              ready,
  output logic              rst_out_n,
  output logic [1:0]        state,
  output logic [7:0]        loss_cnt
);

  localparam int            CW        = (LOCK_WAIT > 2) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [CW-1:0] STAB_LAST = CW'(LOCK_WAIT - 1);
  localparam logic [DW-1:0] DEF_R     = DW'(DEF_DIV);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2,
    LOST      = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic [CW-1:0]          stab_q, stab_d;
  logic [DW-1:0]          cnt_q [NCH];
  logic [DW-1:0]          act_q [NCH];
  logic [DW-1:0]          shd_q [NCH];
  logic [NCH-1:0]         wrap;
  logic                   run_now, run_next;

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Bring the asynchronous lock flag into the clk domain.
  always_ff @(posedge clk) begin
    if (!rstn) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], locked_in};
  end

  // State and stability-counter registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= WAIT_LOCK;
      stab_q  <= '0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
    end
  end

  // Lock qualification: LOCK_WAIT consecutive locked cycles in STABLE before RUN.
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
          stab_d  = '0;
        end
      end
      STABLE: begin
        if (!lock_s)                 state_d = WAIT_LOCK;
        else if (stab_q == STAB_LAST) state_d = RUN;
        else                         stab_d  = stab_q + CW'(1);
      end
      RUN:     if (!lock_s) state_d = LOST;
      LOST:    state_d = WAIT_LOCK;
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Downstream reset is held asserted (low) whenever the sequencer is not in RUN.
  assign run_now   = (state_q == RUN);
  assign run_next  = (state_d == RUN);
  assign ready     = run_now;
  assign rst_out_n = run_now;
  assign state     = state_q;

  // A channel pulses in the last count of its period; disabled channels never pulse.
  always_comb begin
    wrap = '0;
    for (int i = 0; i < NCH; i++) begin
      wrap[i] = run_now && (act_q[i] != '0) && (cnt_q[i] == act_q[i] - DW'(1));
    end
  end

  assign ce_out = wrap;

  // Divider counters: cleared outside RUN and on the cycle RUN is left, ratio swaps only at wrap.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
        act_q[i] <= DEF_R;
        shd_q[i] <= DEF_R;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (cfg_load) shd_q[i] <= div_cfg[i*DW +: DW];
        if (!run_now || (act_q[i] == '0) || wrap[i]) act_q[i] <= shd_q[i];
        if (!run_now || !run_next || (act_q[i] == '0) || wrap[i]) cnt_q[i] <= '0;
        else                                                      cnt_q[i] <= cnt_q[i] + DW'(1);
      end
    end
  end

`ifdef CLOCK_DIV_SEQ_LOSS_CNT_EN
  logic [7:0] loss_q;

  // Count each RUN->LOST transition, sticking at 255.
  always_ff @(posedge clk) begin
    if (!rstn)                                                         loss_q <= '0;
    else if (state_d == LOST && state_q != LOST && loss_q != 8'hFF)    loss_q <= loss_q + 8'd1;
  end

  assign loss_cnt = loss_q;
`else
  assign loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_clock_div_seq.sv
// tb/tb_clock_div_seq.sv - randomized and directed bench for clock_div_seq with behavioural model
module tb_clock_div_seq;

  localparam int NCH = 2;
  localparam int DW  = 8;
  localparam int DEF = 4;
  localparam int LW  = 16;
  localparam int SS  = 2;
`ifdef CLOCK_DIV_SEQ_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstn;
  logic              locked_in;
  logic [NCH*DW-1:0] div_cfg;
  logic              cfg_load;
  logic [NCH-1:0]    ce_out;
  logic              ready;
  logic              rst_out_n;
  logic [1:0]        state;
  logic [7:0]        loss_cnt;

  clock_div_seq #(
    .NCH(NCH), .DW(DW), .DEF_DIV(DEF), .LOCK_WAIT(LW), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .rstn(rstn), .locked_in(locked_in), .div_cfg(div_cfg),
    .cfg_load(cfg_load), .ce_out(ce_out), .ready(ready), .rst_out_n(rst_out_n),
    .state(state), .loss_cnt(loss_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model: lock_s is locked_in delayed SS edges; the sequencer is
  // described by the length of the current locked streak.
  int q[$];
  int streak;
  bit lost;
  int loss;
  int act [NCH];
  int shd [NCH];
  int ph  [NCH];

  function automatic int m_state();
    if (lost)            return 3;
    if (streak == 0)     return 0;
    if (streak <= LW)    return 1;
    return 2;
  endfunction

  function automatic bit m_ce(int i);
    return (m_state() == 2) && (act[i] != 0) && (ph[i] % act[i] == act[i] - 1);
  endfunction

  task automatic model_reset();
    q.delete();
    for (int k = 0; k < SS; k++) q.push_back(0);
    streak = 0;
    lost   = 0;
    loss   = 0;
    for (int i = 0; i < NCH; i++) begin
      act[i] = DEF;
      shd[i] = DEF;
      ph[i]  = 0;
    end
  endtask

  task automatic model_edge();
    int cur, nxt, ls;
    bit wr [NCH];
    if (!rstn) begin
      model_reset();
      return;
    end
    cur = m_state();
    ls  = q[0];
    for (int i = 0; i < NCH; i++) wr[i] = m_ce(i);
    if (lost) begin
      lost   = 0;
      streak = 0;
    end else if (cur == 2) begin
      if (ls == 0) begin
        lost   = 1;
        streak = 0;
        if (loss < 255) loss++;
      end
    end else if (ls != 0) streak++;
    else streak = 0;
    nxt = m_state();
    for (int i = 0; i < NCH; i++) begin
      bit off;
      off = (act[i] == 0);
      if (cur != 2 || nxt != 2 || off || wr[i]) ph[i] = 0;
      else                                      ph[i]++;
      if (cur != 2 || off || wr[i]) act[i] = shd[i];
      if (cfg_load) shd[i] = int'(div_cfg[i*DW +: DW]);
    end
    void'(q.pop_front());
    q.push_back(int'(locked_in));
  endtask

  task automatic check_outputs();
    logic [13:0] got, exp;
    logic [NCH-1:0] ce_e;
    for (int i = 0; i < NCH; i++) ce_e[i] = m_ce(i);
    exp = {2'(m_state()), m_state() == 2, m_state() == 2, ce_e, LOSS_EN ? 8'(loss) : 8'd0};
    got = {state, ready, rst_out_n, ce_out, loss_cnt};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL model_cmp t=%0t: got {state,ready,rstn_o,ce,loss}=%h expected %h", $time, got, exp);
    end
  endtask

  task automatic chk(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    locked_in = 1'b0;
    cfg_load  = 1'b0;
    repeat (2) step();
    rstn = 1'b1;
    repeat (2) step();
  endtask

  task automatic qualify(output int n);
    n = 0;
    while (n < 100 && !ready) begin
      step();
      n++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, c0, c1, bad_ready;
    logic [11:0] m;

    rstn = 1'b0; locked_in = 1'b0; cfg_load = 1'b0; div_cfg = '0;
    model_reset();
    repeat (3) step();
    chk("reset_outputs", int'({state, ready, rst_out_n, ce_out, loss_cnt}), 0);
    rstn = 1'b1;
    repeat (2) step();

    // Qualification latency counted from the first edge sampling locked_in=1.
    locked_in = 1'b1;
    qualify(n);
    chk("ready_latency", n, SS + 1 + LW);
    for (int k = 0; k < 12; k++) begin
      m[k] = ce_out[0];
      step();
    end
    chk("ch0_ce_pattern", int'(m), 12'h888);

    // Lock loss while running.
    locked_in = 1'b0;
    for (int k = 0; k < 10 && state != 2'd3; k++) step();
    chk("lost_state", int'(state), 3);
    chk("lost_ce", int'(ce_out), 0);
    chk("lost_loss_cnt", int'(loss_cnt), LOSS_EN ? 1 : 0);
    step();
    chk("lost_to_wait", int'(state), 0);

    // Lock drop part-way through STABLE.
    do_reset();
    locked_in = 1'b1;
    for (int k = 0; k < 10 && state != 2'd1; k++) step();
    repeat (10) step();
    locked_in = 1'b0;
    bad_ready = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (ready) bad_ready++;
    end
    chk("stable_drop_state", int'(state), 0);
    chk("stable_drop_ready", bad_ready, 0);
    locked_in = 1'b1;
    qualify(n);
    chk("relock_latency", n, SS + 1 + LW);

    // Ratio change 4->3 requested at count 1 of ch1.
    do_reset();
    locked_in = 1'b1;
    qualify(n);
    for (int k = 0; k < 12; k++) begin
      m[k] = ce_out[1];
      cfg_load = (k == 1);
      if (k == 1) div_cfg = {8'd3, 8'd4};
      step();
    end
    cfg_load = 1'b0;
    chk("ch1_ratio_change", int'(m), 12'h248);

    // Ratios {ch1=1, ch0=0}, then reset mid-RUN.
    do_reset();
    div_cfg = {8'd1, 8'd0};
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
    locked_in = 1'b1;
    qualify(n);
    c0 = 0; c1 = 0;
    for (int k = 0; k < 20; k++) begin
      c0 += int'(ce_out[0]);
      c1 += int'(ce_out[1]);
      step();
    end
    chk("ch0_disabled", c0, 0);
    chk("ch1_every_cycle", c1, 20);
    rstn = 1'b0;
    step();
    chk("reset_mid_run", int'({state, ready, rst_out_n, ce_out, loss_cnt}), 0);
    rstn = 1'b1;

    // Saturation of the loss counter.
    do_reset();
    for (int r = 0; r < 300; r++) begin
      locked_in = 1'b1;
      qualify(n);
      locked_in = 1'b0;
      repeat (5) step();
    end
    chk("loss_saturate", int'(loss_cnt), LOSS_EN ? 255 : 0);

    // Randomized lock flapping, config loads and occasional resets.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) < 2) locked_in = ~locked_in;
      cfg_load = ($urandom_range(0, 9) == 0);
      div_cfg  = {8'($urandom_range(0, 6)), 8'($urandom_range(0, 6))};
      rstn     = ($urandom_range(0, 999) >= 3);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
